// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (port 0) and the loader (port 1).
// Grants and memory strobes are combinational; one read may be outstanding, tracked by a small FSM.
module data_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_we,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   state_t     state;
   logic       rr_last;
   logic       owner;
   logic [1:0] counter;
   logic       rsp;
   logic       can_grant;

   // Response cycle doubles as the earliest point a waiting requester can be granted.
   always_comb begin
      rsp       = (state == RD_WAIT) && (counter == LAST_CNT);
      can_grant = reset_n && ((state == IDLE) || rsp);
      gnt       = 2'b00;
      if (can_grant) begin
         case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_comb begin
      mem_en    = |gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt[0]) begin
         mem_we    = req_we[0];
         mem_addr  = req_addr0;
         mem_wdata = req_wdata0;
      end else if (gnt[1]) begin
         mem_we    = req_we[1];
         mem_addr  = req_addr1;
         mem_wdata = req_wdata1;
      end
   end

   always_comb begin
      rvalid = 2'b00;
      rdata  = '0;
      if (rsp) begin
         rvalid = owner ? 2'b10 : 2'b01;
         rdata  = mem_rdata;
      end
   end

   assign busy = (state == RD_WAIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rr_last <= 1'b1;
         owner   <= 1'b0;
         counter <= 2'd0;
      end else begin
         if (|gnt) begin
            rr_last <= gnt[1];
            counter <= 2'd0;
            if (!mem_we) begin
               state <= RD_WAIT;
               owner <= gnt[1];
            end else begin
               state <= IDLE;
            end
         end else if (state == RD_WAIT) begin
            if (rsp) begin
               state   <= IDLE;
               counter <= 2'd0;
            end else begin
               counter <= counter + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: three instances (RD_LAT 1, 2, 3) share one stimulus set,
// each backed by a small read-latency memory model.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid, req_we;
   logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;

   logic [1:0]  g1, g2, g3, rv1, rv2, rv3;
   logic [31:0] rd1, rd2, rd3, ad1, ad2, ad3, wd1, wd2, wd3, md1, md2, md3;
   logic        b1, b2, b3, en1, en2, en3, we1, we2, we3;

   logic [31:0] pa1;
   logic [31:0] pa2 [2];
   logic [31:0] pa3 [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h20:  rom = 32'h0000_1234;
         32'h30:  rom = 32'hA5A5_0030;
         32'h40:  rom = 32'h0BAD_F00D;
         default: rom = 32'hFFFF_FFFF;
      endcase
   endfunction

   always @(posedge clk) begin
      pa1    <= ad1;
      pa2[0] <= ad2;
      pa2[1] <= pa2[0];
      pa3[0] <= ad3;
      pa3[1] <= pa3[0];
      pa3[2] <= pa3[1];
   end

   assign md1 = rom(pa1);
   assign md2 = rom(pa2[1]);
   assign md3 = rom(pa3[2]);

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_l1 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .gnt(g1), .rvalid(rv1), .rdata(rd1), .busy(b1), .mem_en(en1), .mem_we(we1),
      .mem_addr(ad1), .mem_wdata(wd1), .mem_rdata(md1));

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_l2 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .gnt(g2), .rvalid(rv2), .rdata(rd2), .busy(b2), .mem_en(en2), .mem_we(we2),
      .mem_addr(ad2), .mem_wdata(wd2), .mem_rdata(md2));

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_l3 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .gnt(g3), .rvalid(rv3), .rdata(rd3), .busy(b3), .mem_en(en3), .mem_we(we3),
      .mem_addr(ad3), .mem_wdata(wd3), .mem_rdata(md3));

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      req_valid  = 2'b00;
      req_we     = 2'b00;
      req_addr0  = '0;
      req_addr1  = '0;
      req_wdata0 = '0;
      req_wdata1 = '0;
   endtask

   // Leaves the bench 1 ns into the first cycle after reset release.
   task automatic do_reset();
      next_cycle();
      reset_n = 1'b0;
      clear_req();
      next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_req();
      req_valid = 2'b11;
      req_addr0 = 32'h77;
      @(negedge clk);
      checks++; if (g1 !== 2'b00) begin errors++; $display("FAIL reset_gnt1 got %b want 00", g1); end
      checks++; if (g3 !== 2'b00) begin errors++; $display("FAIL reset_gnt3 got %b want 00", g3); end
      checks++; if ({en1, we1, b1, rv1} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {en1, we1, b1, rv1}); end
      checks++; if (ad1 !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", ad1); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rd2); end
      clear_req();
   endtask

   task automatic test_write();
      do_reset();
      req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'h10; req_wdata0 = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (g1 !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b want 01", g1); end
      checks++; if ({en1, we1} !== 2'b11) begin errors++; $display("FAIL wr_en_we got %b want 11", {en1, we1}); end
      checks++; if (ad1 !== 32'h10) begin errors++; $display("FAIL wr_addr got %h want 10", ad1); end
      checks++; if (wd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data got %h want deadbeef", wd1); end
      checks++; if (rv1 !== 2'b00) begin errors++; $display("FAIL wr_rvalid got %b want 00", rv1); end
      next_cycle();
      clear_req();
      @(negedge clk);
      checks++; if ({rv1, b1, en1} !== 4'b0) begin errors++; $display("FAIL wr_after got %b want 0000", {rv1, b1, en1}); end
   endtask

   task automatic test_read_lat1();
      do_reset();
      req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h20;
      @(negedge clk);
      checks++; if (g1 !== 2'b01) begin errors++; $display("FAIL rd1_gnt got %b want 01", g1); end
      checks++; if ({en1, we1} !== 2'b10) begin errors++; $display("FAIL rd1_en_we got %b want 10", {en1, we1}); end
      next_cycle();
      clear_req();
      @(negedge clk);
      checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL rd1_rvalid got %b want 01", rv1); end
      checks++; if (rd1 !== 32'h1234) begin errors++; $display("FAIL rd1_rdata got %h want 1234", rd1); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL rd1_busy got %b want 1", b1); end
      next_cycle();
      @(negedge clk);
      checks++; if ({b1, rv1} !== 3'b000) begin errors++; $display("FAIL rd1_done got %b want 000", {b1, rv1}); end
   endtask

   task automatic test_alternate();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      do_reset();
      req_valid = 2'b11; req_we = 2'b11; req_addr0 = 32'h100; req_addr1 = 32'h200;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_cycle();
         @(negedge clk);
         checks++; if (g1 !== exp_g[i]) begin errors++; $display("FAIL alt_gnt[%0d] got %b want %b", i, g1, exp_g[i]); end
         checks++; if (ad1 !== (exp_g[i][0] ? 32'h100 : 32'h200)) begin errors++; $display("FAIL alt_addr[%0d] got %h", i, ad1); end
      end
      next_cycle();
      clear_req();
   endtask

   task automatic test_hold_lat3();
      do_reset();
      req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h30;
      @(negedge clk);
      checks++; if (g3 !== 2'b01) begin errors++; $display("FAIL hold_issue got %b want 01", g3); end
      next_cycle();
      req_valid = 2'b10; req_we = 2'b10; req_addr1 = 32'h44; req_wdata1 = 32'h55;
      @(negedge clk);
      checks++; if ({g3, en3} !== 3'b000) begin errors++; $display("FAIL hold_t1 got %b want 000", {g3, en3}); end
      checks++; if (b3 !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", b3); end
      next_cycle();
      @(negedge clk);
      checks++; if (g3 !== 2'b00) begin errors++; $display("FAIL hold_t2 got %b want 00", g3); end
      next_cycle();
      @(negedge clk);
      checks++; if (g3 !== 2'b10) begin errors++; $display("FAIL hold_t3_gnt got %b want 10", g3); end
      checks++; if (rv3 !== 2'b01) begin errors++; $display("FAIL hold_t3_rvalid got %b want 01", rv3); end
      checks++; if (rd3 !== 32'hA5A5_0030) begin errors++; $display("FAIL hold_t3_rdata got %h want a5a50030", rd3); end
      checks++; if ({en3, we3, ad3} !== {2'b11, 32'h44}) begin errors++; $display("FAIL hold_t3_mem got %b %h want 11 44", {en3, we3}, ad3); end
      next_cycle();
      clear_req();
      @(negedge clk);
      checks++; if ({b3, rv3} !== 3'b000) begin errors++; $display("FAIL hold_t4 got %b want 000", {b3, rv3}); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h40;
      @(negedge clk);
      checks++; if (g3 !== 2'b10) begin errors++; $display("FAIL mid_issue got %b want 10", g3); end
      next_cycle();
      clear_req();
      reset_n = 1'b0;
      @(negedge clk);
      checks++; if ({g3, rv3, b3, en3} !== 6'b0) begin errors++; $display("FAIL mid_rst_ctl got %b want 000000", {g3, rv3, b3, en3}); end
      checks++; if (rd3 !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", rd3); end
      next_cycle();
      reset_n = 1'b1;
      req_valid = 2'b11; req_we = 2'b11; req_addr0 = 32'h50; req_addr1 = 32'h60;
      @(negedge clk);
      checks++; if (g3 !== 2'b01) begin errors++; $display("FAIL mid_first_gnt got %b want 01", g3); end
      checks++; if (rv3 !== 2'b00) begin errors++; $display("FAIL mid_rv_t2 got %b want 00", rv3); end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge clk);
         checks++; if (rv3 !== 2'b00) begin errors++; $display("FAIL mid_rv_t%0d got %b want 00", i + 3, rv3); end
      end
      next_cycle();
      clear_req();
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h40;
      @(negedge clk);
      checks++; if (g2 !== 2'b10) begin errors++; $display("FAIL b2b_t0 got %b want 10", g2); end
      next_cycle();
      req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h20;
      @(negedge clk);
      checks++; if (g2 !== 2'b00) begin errors++; $display("FAIL b2b_t1 got %b want 00", g2); end
      next_cycle();
      @(negedge clk);
      checks++; if ({g2, rv2} !== 4'b0110) begin errors++; $display("FAIL b2b_t2 got %b want 0110", {g2, rv2}); end
      checks++; if (rd2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_t2_rdata got %h want 0badf00d", rd2); end
      next_cycle();
      clear_req();
      @(negedge clk);
      checks++; if ({g2, rv2, b2} !== 5'b00001) begin errors++; $display("FAIL b2b_t3 got %b want 00001", {g2, rv2, b2}); end
      next_cycle();
      @(negedge clk);
      checks++; if (rv2 !== 2'b01) begin errors++; $display("FAIL b2b_t4 got %b want 01", rv2); end
      checks++; if (rd2 !== 32'h1234) begin errors++; $display("FAIL b2b_t4_rdata got %h want 1234", rd2); end
      next_cycle();
      @(negedge clk);
      checks++; if ({b2, rv2} !== 3'b000) begin errors++; $display("FAIL b2b_t5 got %b want 000", {b2, rv2}); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_lat1();
      test_alternate();
      test_hold_lat3();
      test_reset_mid_read();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
